// File: rtl/lamp_pkg.sv
// rtl/lamp_pkg.sv - shared lamp mode encoding, default timing constants and mode resolution
package lamp_pkg;

    localparam int MODE_W = 4;

    localparam int MODE_L     = 0;
    localparam int MODE_R     = 1;
    localparam int MODE_BRAKE = 2;
    localparam int MODE_DOOR  = 3;

    localparam logic [MODE_W-1:0] MODE_IDLE = 4'b0000;

    // 20 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
    // 200 ms at 50 MHz
    localparam int DEFAULT_BLINK_CYCLES    = 10_000_000;

    typedef logic [MODE_W-1:0] mode_t;

    typedef struct packed {
        logic  conflict;
        mode_t mode;
    } arb_t;

    // A single active level selects its own one-hot mode; none or several
    // fall back to idle, and several additionally raise the conflict flag.
    function automatic arb_t resolve_mode(input mode_t levels);
        arb_t result;
        int   active;
        active = 0;
        for (int i = 0; i < MODE_W; i++) begin
            active += 32'(levels[i]);
        end
        result.conflict = (active >= 2);
        result.mode     = (active == 1) ? levels : MODE_IDLE;
        return result;
    endfunction

endpackage

// File: rtl/lamp_cmd_conditioner_if.sv
// rtl/lamp_cmd_conditioner_if.sv - raw cabin switch inputs and conditioned mode outputs
interface lamp_cmd_conditioner_if;
    import lamp_pkg::*;

    logic  sw_left_raw;
    logic  sw_right_raw;
    logic  sw_brake_raw;
    logic  sw_door_raw;

    mode_t mode;
    logic  mode_chg;
    logic  conflict;
    logic  blink_tick;

    // Switch side: drives the raw levels, observes the conditioned result.
    modport master (
        output sw_left_raw,
        output sw_right_raw,
        output sw_brake_raw,
        output sw_door_raw,
        input  mode,
        input  mode_chg,
        input  conflict,
        input  blink_tick
    );

    // Conditioner side.
    modport slave (
        input  sw_left_raw,
        input  sw_right_raw,
        input  sw_brake_raw,
        input  sw_door_raw,
        output mode,
        output mode_chg,
        output conflict,
        output blink_tick
    );

endinterface

// File: rtl/lamp_cmd_conditioner_sw_debounce.sv
// rtl/lamp_cmd_conditioner_sw_debounce.sv - two-flop synchroniser and stability debounce for one switch
module sw_debounce
    import lamp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rstL,
    input  logic raw,
    output logic level
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] C_TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          st;
    logic [CW-1:0] c;

    // Bring the asynchronous switch into the clk domain.
    always_ff @(posedge clk or posedge rstL) begin
        if (rstL) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Accept a new level only after it differs from st on DEBOUNCE_CYCLES
    // consecutive edges; any return to st restarts the count.
    always_ff @(posedge clk or posedge rstL) begin
        if (rstL) begin
            st <= 1'b0;
            c  <= '0;
        end else if (s2 == st) begin
            c  <= '0;
        end else if (c == C_TERM) begin
            st <= s2;
            c  <= '0;
        end else begin
            c  <= c + CW'(1);
        end
    end

    assign level = st;

endmodule

// File: rtl/lamp_cmd_conditioner.sv
// rtl/lamp_cmd_conditioner.sv - debounced switch arbitration into a one-hot lamp mode plus blink tick
module lamp_cmd_conditioner
    import lamp_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int BLINK_CYCLES    = DEFAULT_BLINK_CYCLES
) (
    input  logic                   clk,
    input  logic                   rstL,
    lamp_cmd_conditioner_if.slave  bus
);

    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [BW-1:0] B_TERM = BW'(BLINK_CYCLES - 1);

    mode_t         level;
    arb_t          arb;
    logic          load;
    mode_t         mode_r;
    logic          conflict_r;
    logic          chg_r;
    logic [BW-1:0] b;

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
        .clk   (clk),
        .rstL  (rstL),
        .raw   (bus.sw_left_raw),
        .level (level[MODE_L])
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
        .clk   (clk),
        .rstL  (rstL),
        .raw   (bus.sw_right_raw),
        .level (level[MODE_R])
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_brake (
        .clk   (clk),
        .rstL  (rstL),
        .raw   (bus.sw_brake_raw),
        .level (level[MODE_BRAKE])
    );

    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_door (
        .clk   (clk),
        .rstL  (rstL),
        .raw   (bus.sw_door_raw),
        .level (level[MODE_DOOR])
    );

    // Resolve the debounced levels; a differing result is loaded next edge.
    always_comb begin
        arb  = resolve_mode(level);
        load = (arb.mode != mode_r);
    end

    // Register mode and conflict; mode_chg marks the first cycle of a new mode.
    always_ff @(posedge clk or posedge rstL) begin
        if (rstL) begin
            mode_r     <= MODE_IDLE;
            conflict_r <= 1'b0;
            chg_r      <= 1'b0;
        end else begin
            mode_r     <= arb.mode;
            conflict_r <= arb.conflict;
            chg_r      <= load;
        end
    end

    // Free-running blink phase, restarted whenever a new mode is loaded so
    // every pattern begins from a fresh full period.
    always_ff @(posedge clk or posedge rstL) begin
        if (rstL) begin
            b <= '0;
        end else if (load) begin
            b <= '0;
        end else if (b == B_TERM) begin
            b <= '0;
        end else begin
            b <= b + BW'(1);
        end
    end

    assign bus.mode       = mode_r;
    assign bus.conflict   = conflict_r;
    assign bus.mode_chg   = chg_r;
    // The restart wins over the terminal count, so the tick is withheld in
    // the cycle whose closing edge loads a new mode.
    assign bus.blink_tick = (b == B_TERM) && !load;

endmodule

// File: tb/tb_lamp_cmd_conditioner.sv
// tb/tb_lamp_cmd_conditioner.sv - randomized and directed self-checking bench for lamp_cmd_conditioner
module tb_lamp_cmd_conditioner;
    import lamp_pkg::*;

    localparam int D = 4;
    localparam int B = 8;

    logic clk  = 1'b0;
    logic rstL = 1'b1;
    int   checks = 0;
    int   errors = 0;

    lamp_cmd_conditioner_if bus();

    lamp_cmd_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .BLINK_CYCLES    (B)
    ) dut (
        .clk  (clk),
        .rstL (rstL),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference model: a switch level counts once its synchronised value
    // (the raw sample from two edges earlier) has been one value for the
    // last D edges; mode follows the accepted levels one edge later; the
    // tick fires every B-th edge counted from the last mode load.
    logic [3:0] raw_q[$];
    logic [3:0] m_st     = 4'b0;
    logic [3:0] m_mode   = 4'b0;
    logic       m_conf   = 1'b0;
    logic       m_chg    = 1'b0;
    logic       m_tick   = 1'b0;
    int         m_age    = 0;
    int         m_chg_count = 0;

    function automatic logic [3:0] ref_mode(input logic [3:0] v);
        return ($countones(v) == 1) ? v : 4'b0000;
    endfunction

    function automatic logic ref_conf(input logic [3:0] v);
        return ($countones(v) >= 2);
    endfunction

    function automatic logic sync_at(input int j, input int ch);
        logic [3:0] v;
        if (j < 2) return 1'b0;
        v = raw_q[j-2];
        return v[ch];
    endfunction

    task automatic model_edge();
        logic [3:0] rv;
        logic [3:0] nst;
        int         n;
        int         ones;
        rv = {bus.sw_door_raw, bus.sw_brake_raw, bus.sw_right_raw, bus.sw_left_raw};
        raw_q.push_back(rv);
        n = raw_q.size() - 1;
        m_chg = (ref_mode(m_st) != m_mode);
        if (m_chg) begin
            m_age = 0;
            m_chg_count++;
        end else begin
            m_age++;
        end
        m_mode = ref_mode(m_st);
        m_conf = ref_conf(m_st);
        nst = m_st;
        for (int ch = 0; ch < 4; ch++) begin
            ones = 0;
            for (int j = n - D + 1; j <= n; j++) ones += 32'(sync_at(j, ch));
            if (ones == D) nst[ch] = 1'b1;
            if (ones == 0) nst[ch] = 1'b0;
        end
        m_st = nst;
        m_tick = ((m_age % B) == B - 1) && (ref_mode(m_st) == m_mode);
    endtask

    // Cycle-by-cycle scoreboard against the reference model.
    always @(posedge clk) begin
        #1;
        if (rstL) begin
            raw_q.delete();
            m_st = 4'b0; m_mode = 4'b0; m_conf = 1'b0; m_chg = 1'b0; m_tick = 1'b0; m_age = 0;
        end else begin
            model_edge();
        end
        checks++;
        if (bus.mode !== m_mode) begin
            errors++; $display("FAIL scoreboard mode: got %b expected %b at %0t", bus.mode, m_mode, $time);
        end
        checks++;
        if (bus.conflict !== m_conf) begin
            errors++; $display("FAIL scoreboard conflict: got %b expected %b at %0t", bus.conflict, m_conf, $time);
        end
        checks++;
        if (bus.mode_chg !== m_chg) begin
            errors++; $display("FAIL scoreboard mode_chg: got %b expected %b at %0t", bus.mode_chg, m_chg, $time);
        end
        checks++;
        if (bus.blink_tick !== m_tick) begin
            errors++; $display("FAIL scoreboard blink_tick: got %b expected %b at %0t", bus.blink_tick, m_tick, $time);
        end
    end

    // Edges (1-based) until mode_chg is seen, or -1 within the bound.
    task automatic wait_chg(input int bound, output int k_found);
        k_found = -1;
        for (int k = 1; k <= bound; k++) begin
            @(posedge clk); #2;
            if (bus.mode_chg === 1'b1) begin
                k_found = k;
                break;
            end
        end
    endtask

    task automatic wait_tick(input int bound, output int k_found);
        k_found = -1;
        for (int k = 1; k <= bound; k++) begin
            @(posedge clk); #2;
            if (bus.blink_tick === 1'b1) begin
                k_found = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.sw_left_raw = 1'b1; bus.sw_right_raw = 1'b1;
        bus.sw_brake_raw = 1'b1; bus.sw_door_raw = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (bus.mode !== 4'b0000) begin errors++; $display("FAIL reset mode: got %b expected 0000", bus.mode); end
        checks++;
        if (bus.conflict !== 1'b0) begin errors++; $display("FAIL reset conflict: got %b expected 0", bus.conflict); end
        checks++;
        if (bus.mode_chg !== 1'b0) begin errors++; $display("FAIL reset mode_chg: got %b expected 0", bus.mode_chg); end
        checks++;
        if (bus.blink_tick !== 1'b0) begin errors++; $display("FAIL reset blink_tick: got %b expected 0", bus.blink_tick); end
        bus.sw_left_raw = 1'b0; bus.sw_right_raw = 1'b0;
        bus.sw_brake_raw = 1'b0; bus.sw_door_raw = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstL = 1'b0;
    endtask

    task automatic test_idle();
        int ticks = 0;
        int chgs  = 0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #2;
            if (bus.blink_tick === 1'b1) ticks++;
            if (bus.mode_chg === 1'b1) chgs++;
        end
        checks++;
        if (ticks !== 3) begin errors++; $display("FAIL idle tick count: got %0d expected 3", ticks); end
        checks++;
        if (chgs !== 0) begin errors++; $display("FAIL idle mode_chg count: got %0d expected 0", chgs); end
        checks++;
        if (bus.mode !== 4'b0000) begin errors++; $display("FAIL idle mode: got %b expected 0000", bus.mode); end
    endtask

    task automatic test_glitch();
        int chgs = 0;
        @(negedge clk); bus.sw_brake_raw = 1'b1;
        repeat (3) @(negedge clk);
        bus.sw_brake_raw = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #2;
            if (bus.mode_chg === 1'b1) chgs++;
        end
        checks++;
        if (chgs !== 0) begin errors++; $display("FAIL glitch mode_chg count: got %0d expected 0", chgs); end
        checks++;
        if (bus.mode !== 4'b0000) begin errors++; $display("FAIL glitch mode: got %b expected 0000", bus.mode); end
    endtask

    task automatic test_left_press();
        int k_chg;
        int k_tick;
        @(negedge clk); bus.sw_left_raw = 1'b1;
        wait_chg(20, k_chg);
        checks++;
        if (k_chg !== D + 3) begin errors++; $display("FAIL press latency: got %0d expected %0d", k_chg, D + 3); end
        checks++;
        if (bus.mode !== 4'b0001) begin errors++; $display("FAIL press mode: got %b expected 0001", bus.mode); end
        wait_tick(2 * B, k_tick);
        checks++;
        if (k_tick !== B - 1) begin errors++; $display("FAIL press first tick: got %0d expected %0d", k_tick, B - 1); end
        wait_tick(2 * B, k_tick);
        checks++;
        if (k_tick !== B) begin errors++; $display("FAIL press tick period: got %0d expected %0d", k_tick, B); end
    endtask

    task automatic test_conflict();
        int k_chg;
        int chgs = 0;
        @(negedge clk); bus.sw_right_raw = 1'b1;
        wait_chg(20, k_chg);
        checks++;
        if (k_chg !== D + 3) begin errors++; $display("FAIL conflict latency: got %0d expected %0d", k_chg, D + 3); end
        checks++;
        if (bus.mode !== 4'b0000) begin errors++; $display("FAIL conflict mode: got %b expected 0000", bus.mode); end
        checks++;
        if (bus.conflict !== 1'b1) begin errors++; $display("FAIL conflict flag: got %b expected 1", bus.conflict); end
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #2;
            if (bus.mode_chg === 1'b1) chgs++;
        end
        checks++;
        if (chgs !== 0) begin errors++; $display("FAIL conflict extra pulses: got %0d expected 0", chgs); end
        @(negedge clk); bus.sw_right_raw = 1'b0;
        wait_chg(20, k_chg);
        checks++;
        if (k_chg !== D + 3) begin errors++; $display("FAIL unconflict latency: got %0d expected %0d", k_chg, D + 3); end
        checks++;
        if (bus.mode !== 4'b0001 || bus.conflict !== 1'b0) begin
            errors++; $display("FAIL unconflict state: got mode %b conflict %b expected 0001/0", bus.mode, bus.conflict);
        end
    endtask

    task automatic test_release();
        int k_chg;
        int k_tick;
        @(negedge clk); bus.sw_left_raw = 1'b0;
        wait_chg(20, k_chg);
        checks++;
        if (k_chg !== D + 3) begin errors++; $display("FAIL release latency: got %0d expected %0d", k_chg, D + 3); end
        checks++;
        if (bus.mode !== 4'b0000) begin errors++; $display("FAIL release mode: got %b expected 0000", bus.mode); end
        wait_tick(2 * B, k_tick);
        checks++;
        if (k_tick !== B - 1) begin errors++; $display("FAIL release first tick: got %0d expected %0d", k_tick, B - 1); end
    endtask

    task automatic test_reset_mid_debounce();
        int k_chg;
        @(negedge clk); bus.sw_door_raw = 1'b1;
        repeat (5) @(negedge clk);
        rstL = 1'b1;
        repeat (2) @(negedge clk);
        rstL = 1'b0;
        wait_chg(20, k_chg);
        checks++;
        if (k_chg !== D + 3) begin errors++; $display("FAIL reset-mid latency: got %0d expected %0d", k_chg, D + 3); end
        checks++;
        if (bus.mode !== 4'b1000) begin errors++; $display("FAIL reset-mid mode: got %b expected 1000", bus.mode); end
    endtask

    task automatic test_async_reset();
        @(negedge clk); #1;
        rstL = 1'b1;
        #1;
        checks++;
        if (bus.mode !== 4'b0000 || bus.mode_chg !== 1'b0 || bus.conflict !== 1'b0 || bus.blink_tick !== 1'b0) begin
            errors++;
            $display("FAIL async reset: got mode %b chg %b conflict %b tick %b expected all 0",
                     bus.mode, bus.mode_chg, bus.conflict, bus.blink_tick);
        end
        bus.sw_door_raw = 1'b0;
        repeat (2) @(negedge clk);
        rstL = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0] v;
        int         hold;
        int         cyc = 0;
        int         seen = 0;
        int         start_count;
        @(negedge clk);
        start_count = m_chg_count;
        while (cyc < 2500) begin
            case ($urandom_range(0, 3))
                0: v = 4'b0000;
                1: v = 4'b0001 << $urandom_range(0, 3);
                2: v = 4'($urandom_range(0, 15));
                default: v = {bus.sw_door_raw, bus.sw_brake_raw, bus.sw_right_raw, bus.sw_left_raw}
                             ^ (4'b0001 << $urandom_range(0, 3));
            endcase
            {bus.sw_door_raw, bus.sw_brake_raw, bus.sw_right_raw, bus.sw_left_raw} = v;
            if ($urandom_range(0, 199) == 0) begin
                rstL = 1'b1;
                repeat (2) begin
                    @(negedge clk);
                    if (bus.mode_chg === 1'b1) seen++;
                end
                rstL = 1'b0;
                cyc += 2;
            end
            hold = $urandom_range(1, 2 * D + 2);
            repeat (hold) begin
                @(negedge clk);
                if (bus.mode_chg === 1'b1) seen++;
            end
            cyc += hold;
        end
        checks++;
        if (seen !== m_chg_count - start_count) begin
            errors++; $display("FAIL random mode_chg total: got %0d expected %0d", seen, m_chg_count - start_count);
        end
    endtask

    initial begin
        bus.sw_left_raw  = 1'b0;
        bus.sw_right_raw = 1'b0;
        bus.sw_brake_raw = 1'b0;
        bus.sw_door_raw  = 1'b0;
        test_reset();
        test_idle();
        test_glitch();
        test_left_press();
        test_conflict();
        test_release();
        test_reset_mid_debounce();
        test_async_reset();
        test_random();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
